dp_sequencer: RTL

Moore-style controller that sequences the 8×16-bit register file and its ALU datapath. It accepts one command per start/done handshake and drives the register-file read/write selects and the pipeline load enables in a fixed cycle order. It also drives the ALU and mux selects. It sits between the command source (switch/instruction logic) and the datapath, and owns every write strobe into the register file.

---
 rtl/dp_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dp_sequencer.sv
// ============================================================================
// Module      : dp_sequencer
// Description : Moore controller sequencing the 8x16 register file and ALU
//               datapath through one command per start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] rd,
  input  logic [2:0] rn,
  input  logic [2:0] rm,
  output logic [2:0] readnum,
  output logic [2:0] writenum,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       vsel,
  output logic [1:0] aluop,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;
  localparam logic [2:0] OP_MVN  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, rd_q, rn_q, rm_q;
  logic       illegal_w;

  assign illegal_w = (op_q[2:1] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      rd_q    <= 3'd0;
      rn_q    <= 3'd0;
      rm_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q <= op;
        rd_q <= rd;
        rn_q <= rn;
        rm_q <= rm;
      end
    end
  end

  // The dispatch edge branches on the live op; later states use the captured copy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MOVI:                state_d = S_WRITE;
            OP_MOV, OP_MVN:         state_d = S_LOADB;
            OP_ADD, OP_AND, OP_CMP: state_d = S_LOADA;
            default:                state_d = S_DONE;
          endcase
        end
      end
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_CMP) ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 1'b0;
    aluop    = 2'b00;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_LOADA: begin
        readnum = rn_q;
        loada   = 1'b1;
      end
      S_LOADB: begin
        readnum = rm_q;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        loads = (op_q == OP_CMP);
        loadc = (op_q != OP_CMP);
        asel  = (op_q == OP_MOV);
        case (op_q)
          OP_CMP:  aluop = 2'b01;
          OP_AND:  aluop = 2'b10;
          OP_MVN:  aluop = 2'b11;
          default: aluop = 2'b00;
        endcase
      end
      S_WRITE: begin
        writenum = rd_q;
        write    = 1'b1;
        vsel     = (op_q == OP_MOVI);
      end
      S_DONE: begin
        done = 1'b1;
        err  = illegal_w;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
